// File: rtl/debounce_pkg.sv
// Shared types, constants and helpers for the multi-channel button conditioner.
package debounce_pkg;

  // Per-channel hold/auto-repeat state
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2,
    ST_REPEAT  = 2'd3
  } hold_state_e;

  // Default timing, in prescale tick periods
  localparam int unsigned DEFAULT_DEB_TICKS    = 16;
  localparam int unsigned DEFAULT_HOLD_TICKS   = 1000;
  localparam int unsigned DEFAULT_REPEAT_TICKS = 200;

  // Bits needed to hold values 0..value-1; never returns less than 1
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned w;
    w = 1;
    while ((64'(1) << w) < 64'(value)) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchroniser, tick-gated debounce counter,
// press/release pulses and the long-press / auto-repeat hold FSM.
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned ACTIVE_LOW   = 1,
  parameter int unsigned DEB_TICKS    = DEFAULT_DEB_TICKS,
  parameter int unsigned HOLD_TICKS   = DEFAULT_HOLD_TICKS,
  parameter int unsigned REPEAT_TICKS = DEFAULT_REPEAT_TICKS
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic pb_raw,
  output logic pb_state,
  output logic pb_down,
  output logic pb_up,
  output logic long_press,
  output logic repeat_pulse
);

  localparam int unsigned DEB_W    = clog2(DEB_TICKS + 1);
  localparam int unsigned HOLD_MAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
  localparam int unsigned HOLD_W   = clog2(HOLD_MAX + 1);
  localparam int unsigned REP_LAST = (REPEAT_TICKS > 0) ? (REPEAT_TICKS - 1) : 0;

  logic              sync1_q, sync1_d;
  logic              sync_q, sync_d;
  logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d;
  logic              pb_state_q, pb_state_d;
  logic              pb_down_q, pb_down_d;
  logic              pb_up_q, pb_up_d;
  hold_state_e       hold_st_q, hold_st_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              long_q, long_d;
  logic              rep_q, rep_d;

  // Synchroniser with polarity normalised so that 1 = pressed
  always_comb begin
    sync1_d = (ACTIVE_LOW != 0) ? ~pb_raw : pb_raw;
    sync_d  = sync1_q;
  end

  // Debounce: count consecutive disagreeing ticks, flip level on the last one
  always_comb begin
    deb_cnt_d  = deb_cnt_q;
    pb_state_d = pb_state_q;
    pb_down_d  = 1'b0;
    pb_up_d    = 1'b0;
    if (sync_q == pb_state_q) begin
      deb_cnt_d = '0;
    end else if (tick) begin
      if (deb_cnt_q == DEB_W'(DEB_TICKS - 1)) begin
        pb_state_d = sync_q;
        deb_cnt_d  = '0;
        pb_down_d  = sync_q;
        pb_up_d    = ~sync_q;
      end else begin
        deb_cnt_d = deb_cnt_q + DEB_W'(1);
      end
    end
  end

  // Hold FSM: long press after HOLD_TICKS, then repeat every REPEAT_TICKS; release wins
  always_comb begin
    hold_st_d  = hold_st_q;
    hold_cnt_d = hold_cnt_q;
    long_d     = 1'b0;
    rep_d      = 1'b0;
    if (pb_up_d) begin
      hold_st_d  = ST_IDLE;
      hold_cnt_d = '0;
    end else begin
      case (hold_st_q)
        ST_IDLE: begin
          if (pb_down_d) begin
            hold_st_d  = ST_PRESSED;
            hold_cnt_d = '0;
          end
        end
        ST_PRESSED: begin
          if (tick) begin
            if (hold_cnt_q == HOLD_W'(HOLD_TICKS - 1)) begin
              long_d     = 1'b1;
              hold_cnt_d = '0;
              hold_st_d  = ST_HELD;
            end else begin
              hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
          end
        end
        ST_HELD, ST_REPEAT: begin
          if ((REPEAT_TICKS != 0) && tick) begin
            if (hold_cnt_q == HOLD_W'(REP_LAST)) begin
              rep_d      = 1'b1;
              hold_cnt_d = '0;
              hold_st_d  = ST_REPEAT;
            end else begin
              hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
          end
        end
        default: begin
          hold_st_d  = ST_IDLE;
          hold_cnt_d = '0;
        end
      endcase
    end
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q    <= 1'b0;
      sync_q     <= 1'b0;
      deb_cnt_q  <= '0;
      pb_state_q <= 1'b0;
      pb_down_q  <= 1'b0;
      pb_up_q    <= 1'b0;
      hold_st_q  <= ST_IDLE;
      hold_cnt_q <= '0;
      long_q     <= 1'b0;
      rep_q      <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync_q     <= sync_d;
      deb_cnt_q  <= deb_cnt_d;
      pb_state_q <= pb_state_d;
      pb_down_q  <= pb_down_d;
      pb_up_q    <= pb_up_d;
      hold_st_q  <= hold_st_d;
      hold_cnt_q <= hold_cnt_d;
      long_q     <= long_d;
      rep_q      <= rep_d;
    end
  end

  assign pb_state     = pb_state_q;
  assign pb_down      = pb_down_q;
  assign pb_up        = pb_up_q;
  assign long_press   = long_q;
  assign repeat_pulse = rep_q;

endmodule

// File: rtl/multi_debouncer.sv
// NUM_CH independent button conditioners sharing clk, reset and the prescale tick.
module multi_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned ACTIVE_LOW   = 1,
  parameter int unsigned DEB_TICKS    = DEFAULT_DEB_TICKS,
  parameter int unsigned HOLD_TICKS   = DEFAULT_HOLD_TICKS,
  parameter int unsigned REPEAT_TICKS = DEFAULT_REPEAT_TICKS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic [NUM_CH-1:0] pb_raw,
  output logic [NUM_CH-1:0] pb_state,
  output logic [NUM_CH-1:0] pb_down,
  output logic [NUM_CH-1:0] pb_up,
  output logic [NUM_CH-1:0] long_press,
  output logic [NUM_CH-1:0] repeat_pulse
);

  // One conditioner per button pin
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    debounce_channel #(
      .ACTIVE_LOW   (ACTIVE_LOW),
      .DEB_TICKS    (DEB_TICKS),
      .HOLD_TICKS   (HOLD_TICKS),
      .REPEAT_TICKS (REPEAT_TICKS)
    ) u_ch (
      .clk          (clk),
      .reset        (reset),
      .tick         (tick),
      .pb_raw       (pb_raw[g]),
      .pb_state     (pb_state[g]),
      .pb_down      (pb_down[g]),
      .pb_up        (pb_up[g]),
      .long_press   (long_press[g]),
      .repeat_pulse (repeat_pulse[g])
    );
  end

endmodule

// File: tb/tb_multi_debouncer.sv
// Directed bench for multi_debouncer with 2 active-low channels, DEB=4, HOLD=10, REPEAT=3.
module tb_multi_debouncer;

  localparam int unsigned NUM_CH = 2;

  logic              clk;
  logic              reset;
  logic              tick;
  logic [NUM_CH-1:0] pb_raw;
  logic [NUM_CH-1:0] pb_state;
  logic [NUM_CH-1:0] pb_down;
  logic [NUM_CH-1:0] pb_up;
  logic [NUM_CH-1:0] long_press;
  logic [NUM_CH-1:0] repeat_pulse;

  int n_checks;
  int n_pass;

  logic              prescale;
  logic [1:0]        pcnt;
  logic [NUM_CH-1:0] seen_down, seen_up, seen_long, seen_rep;

  multi_debouncer #(
    .NUM_CH       (NUM_CH),
    .ACTIVE_LOW   (1),
    .DEB_TICKS    (4),
    .HOLD_TICKS   (10),
    .REPEAT_TICKS (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .tick         (tick),
    .pb_raw       (pb_raw),
    .pb_state     (pb_state),
    .pb_down      (pb_down),
    .pb_up        (pb_up),
    .long_press   (long_press),
    .repeat_pulse (repeat_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Advance one clock edge, then drive tick for the next edge and record pulses
  task automatic step();
    @(posedge clk);
    #1;
    pcnt = pcnt + 2'd1;
    tick = (prescale == 1'b0) || (pcnt == 2'd0);
    seen_down |= pb_down;
    seen_up   |= pb_up;
    seen_long |= long_press;
    seen_rep  |= repeat_pulse;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_seen();
    seen_down = '0;
    seen_up   = '0;
    seen_long = '0;
    seen_rep  = '0;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    prescale = 1'b0;
    pcnt     = 2'd0;
    tick     = 1'b1;
    reset    = 1'b0;
    pb_raw   = 2'b11;
    clear_seen();

    // Reset state
    steps(3);
    check_eq("rst_state", 32'(pb_state), 32'h0);
    check_eq("rst_pulses", 32'({pb_down, pb_up, long_press, repeat_pulse}), 32'h0);
    reset = 1'b1;
    steps(3);
    check_eq("idle_state", 32'(pb_state), 32'h0);

    // Clean press on ch0: pb_down 6 edges after the change
    clear_seen();
    pb_raw[0] = 1'b0;
    steps(5);
    check_eq("press_early_state", 32'(pb_state), 32'h0);
    check_eq("press_early_down", 32'(seen_down), 32'h0);
    step();
    check_eq("press_state", 32'(pb_state), 32'h1);
    check_eq("press_down", 32'(pb_down), 32'h1);
    step();
    check_eq("press_down_1cyc", 32'(pb_down), 32'h0);
    check_eq("press_ch1_quiet", 32'(pb_state[1]), 32'h0);
    pb_raw[0] = 1'b1;
    steps(6);
    check_eq("release_up", 32'(pb_up), 32'h1);
    check_eq("release_state", 32'(pb_state), 32'h0);
    check_eq("release_no_long", 32'(seen_long), 32'h0);
    steps(4);

    // Bounce rejection on ch0
    clear_seen();
    for (int i = 0; i < 10; i++) begin
      pb_raw[0] = ~pb_raw[0];
      steps(2);
    end
    pb_raw[0] = 1'b0;
    steps(5);
    check_eq("bounce_no_down", 32'(seen_down), 32'h0);
    check_eq("bounce_no_up", 32'(seen_up), 32'h0);
    check_eq("bounce_state", 32'(pb_state), 32'h0);
    step();
    check_eq("bounce_down", 32'(pb_down), 32'h1);
    pb_raw[0] = 1'b1;
    steps(6);
    check_eq("bounce_up", 32'(pb_up), 32'h1);
    steps(4);

    // Long press and repeat on ch1
    pb_raw[1] = 1'b0;
    steps(6);
    check_eq("lp_down", 32'(pb_down), 32'h2);
    clear_seen();
    steps(9);
    check_eq("lp_early", 32'(seen_long), 32'h0);
    step();
    check_eq("lp_long", 32'(long_press), 32'h2);
    step();
    check_eq("lp_long_1cyc", 32'(long_press), 32'h0);
    step();
    check_eq("lp_rep_early", 32'(seen_rep), 32'h0);
    step();
    check_eq("lp_rep13", 32'(repeat_pulse), 32'h2);
    steps(3);
    check_eq("lp_rep16", 32'(repeat_pulse), 32'h2);
    steps(2);
    check_eq("lp_rep_gap", 32'(repeat_pulse), 32'h0);
    step();
    check_eq("lp_rep19", 32'(repeat_pulse), 32'h2);
    steps(11);
    pb_raw[1] = 1'b1;
    steps(6);
    check_eq("lp_up", 32'(pb_up), 32'h2);
    clear_seen();
    steps(10);
    check_eq("lp_no_rep_after", 32'(seen_rep), 32'h0);
    check_eq("lp_no_long_after", 32'(seen_long), 32'h0);

    // Prescale: tick lands on edges +3, +7, +11, +15 relative to the press
    pcnt     = 2'd2;
    prescale = 1'b1;
    pb_raw[0] = 1'b0;
    clear_seen();
    steps(14);
    check_eq("pre_hold", 32'(pb_state), 32'h0);
    check_eq("pre_no_down", 32'(seen_down), 32'h0);
    step();
    check_eq("pre_down", 32'(pb_down), 32'h1);
    prescale = 1'b0;
    tick     = 1'b1;
    pb_raw[0] = 1'b1;
    steps(6);
    check_eq("pre_up", 32'(pb_up), 32'h1);
    steps(4);

    // Reset while ch0 is in HELD
    pb_raw[0] = 1'b0;
    steps(6);
    check_eq("rh_down", 32'(pb_down), 32'h1);
    steps(10);
    check_eq("rh_long", 32'(long_press), 32'h1);
    step();
    reset = 1'b0;
    clear_seen();
    step();
    reset = 1'b1;
    check_eq("rh_state", 32'(pb_state), 32'h0);
    check_eq("rh_pulses", 32'({pb_down, pb_up, long_press, repeat_pulse}), 32'h0);
    steps(5);
    check_eq("rh_no_up", 32'(seen_up), 32'h0);
    check_eq("rh_early_down", 32'(seen_down), 32'h0);
    step();
    check_eq("rh_redown", 32'(pb_down), 32'h1);

    // Release coinciding with the pending long press
    steps(4);
    pb_raw[0] = 1'b1;
    clear_seen();
    steps(6);
    check_eq("sim_up", 32'(pb_up), 32'h1);
    check_eq("sim_no_long", 32'(long_press), 32'h0);
    clear_seen();
    steps(12);
    check_eq("sim_idle_long", 32'(seen_long), 32'h0);
    check_eq("sim_idle_rep", 32'(seen_rep), 32'h0);

    // Re-press after the coincident release: hold FSM must restart from IDLE
    pb_raw[0] = 1'b0;
    steps(6);
    check_eq("re_down", 32'(pb_down), 32'h1);
    clear_seen();
    steps(9);
    check_eq("re_long_early", 32'(seen_long), 32'h0);
    step();
    check_eq("re_long", 32'(long_press), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
